// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
//   Packet controller between a UART receiver and transmitter, both on
//   AXI-Stream style byte channels.  A packet is a 4-byte header (opcode,
//   reserved, length low, length high) followed by (length - 4) payload
//   bytes.  Echo packets stream their payload straight to tx.  Add packets
//   sum their payload as little-endian 32-bit words and return the 32-bit
//   sum as 4 bytes, LSB first.  Unknown opcodes flag err_op_o and drop
//   their payload.
//
// Ports
//   clk_i        single clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   rx_tdata_i   byte from UART receiver
//   rx_tvalid_i  rx byte valid
//   rx_tready_o  controller accepts rx byte
//   tx_tdata_o   byte to UART transmitter
//   tx_tvalid_o  tx byte valid
//   tx_tready_i  transmitter accepts byte
//   busy_o       high whenever a packet is being processed
//   err_op_o     one-cycle pulse when an unknown opcode's header completes
module uart_alu_ctrl #(
   parameter logic [7:0] OP_ECHO_P = 8'hEC,
   parameter logic [7:0] OP_ADD_P  = 8'hAD
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [7:0] rx_tdata_i,
   input  logic       rx_tvalid_i,
   output logic       rx_tready_o,
   output logic [7:0] tx_tdata_o,
   output logic       tx_tvalid_o,
   input  logic       tx_tready_i,
   output logic       busy_o,
   output logic       err_op_o
);

   typedef enum logic [2:0] {
      S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_ACC, S_SEND, S_DRAIN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  opcode;
   logic [7:0]  len_lo;
   logic [15:0] rem;        // payload bytes still to come
   logic [31:0] acc;
   logic [31:0] opnd;       // operand being assembled from payload bytes
   logic [1:0]  byte_idx;   // byte lane of the next payload byte in opnd
   logic [1:0]  tx_idx;     // which acc byte is on tx in SEND

   logic [15:0] len_full;
   logic [15:0] pay_cnt;
   logic [31:0] opnd_nxt;
   logic        last_byte;
   logic        rx_hs;
   logic        tx_hs;

   assign len_full  = {rx_tdata_i, len_lo};
   // Lengths shorter than the header itself mean an empty payload.
   assign pay_cnt   = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
   assign opnd_nxt  = opnd | ({24'd0, rx_tdata_i} << {byte_idx, 3'b000});
   assign last_byte = (rem == 16'd1);
   assign rx_hs     = rx_tvalid_i & rx_tready_o;
   assign tx_hs     = tx_tvalid_o & tx_tready_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= S_OPCODE;
      end else begin
         state <= state_nxt;
      end
   end

   // Outputs are gated by reset_n_i so they read as idle while reset is held,
   // and rx_tready_o rises in the very first cycle after release.
   always_comb begin
      state_nxt   = state;
      rx_tready_o = 1'b0;
      tx_tvalid_o = 1'b0;
      tx_tdata_o  = 8'd0;
      busy_o      = 1'b0;
      err_op_o    = 1'b0;
      if (reset_n_i) begin
         busy_o = (state != S_OPCODE);
         case (state)
            S_OPCODE: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i) state_nxt = S_RSVD;
            end
            S_RSVD: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i) begin
                  if (opcode == OP_ECHO_P) begin
                     state_nxt = (pay_cnt == 16'd0) ? S_OPCODE : S_ECHO;
                  end else if (opcode == OP_ADD_P) begin
                     state_nxt = (pay_cnt == 16'd0) ? S_SEND : S_ACC;
                  end else begin
                     err_op_o  = 1'b1;
                     state_nxt = (pay_cnt == 16'd0) ? S_OPCODE : S_DRAIN;
                  end
               end
            end
            S_ECHO: begin
               // Straight pass-through; the transmitter's ready paces rx.
               tx_tdata_o  = rx_tdata_i;
               tx_tvalid_o = rx_tvalid_i;
               rx_tready_o = tx_tready_i;
               if (rx_tvalid_i && tx_tready_i && last_byte) state_nxt = S_OPCODE;
            end
            S_ACC: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i && last_byte) state_nxt = S_SEND;
            end
            S_SEND: begin
               tx_tvalid_o = 1'b1;
               tx_tdata_o  = acc[{tx_idx, 3'b000} +: 8];
               if (tx_tready_i && (tx_idx == 2'd3)) state_nxt = S_OPCODE;
            end
            S_DRAIN: begin
               rx_tready_o = 1'b1;
               if (rx_tvalid_i && last_byte) state_nxt = S_OPCODE;
            end
            default: state_nxt = S_OPCODE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         opcode   <= 8'd0;
         len_lo   <= 8'd0;
         rem      <= 16'd0;
         acc      <= 32'd0;
         opnd     <= 32'd0;
         byte_idx <= 2'd0;
         tx_idx   <= 2'd0;
      end else begin
         case (state)
            S_OPCODE: if (rx_hs) opcode <= rx_tdata_i;
            S_LEN_LO: if (rx_hs) len_lo <= rx_tdata_i;
            S_LEN_HI: begin
               if (rx_hs) begin
                  rem      <= pay_cnt;
                  acc      <= 32'd0;
                  opnd     <= 32'd0;
                  byte_idx <= 2'd0;
                  tx_idx   <= 2'd0;
               end
            end
            S_ECHO, S_DRAIN: if (rx_hs) rem <= rem - 16'd1;
            S_ACC: begin
               if (rx_hs) begin
                  rem <= rem - 16'd1;
                  // A full word, or the zero-extended tail of the payload,
                  // is folded into the sum on the byte that completes it.
                  if ((byte_idx == 2'd3) || last_byte) begin
                     acc      <= acc + opnd_nxt;
                     opnd     <= 32'd0;
                     byte_idx <= 2'd0;
                  end else begin
                     opnd     <= opnd_nxt;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            S_SEND: if (tx_hs) tx_idx <= tx_idx + 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
`timescale 1ns/1ps
module tb_uart_alu_ctrl;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;

   typedef logic [7:0] bq_t[$];

   logic       clk;
   logic       reset_n;
   logic [7:0] rx_tdata;
   logic       rx_tvalid;
   logic       rx_tready_o;
   logic [7:0] tx_tdata_o;
   logic       tx_tvalid_o;
   logic       tx_tready;
   logic       busy_o;
   logic       err_op_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   tx_mode;      // 0 ready high, 1 random, 2 toggle, 3 held low
   int   gap_pct;      // chance of an idle rx cycle
   int   err_cnt = 0;
   int   err_base;
   int   got_base;
   int   exp_err;
   bq_t  got_q;
   bq_t  exp_q;
   bq_t  pkt;
   logic [7:0] hold_data;

   uart_alu_ctrl #(.OP_ECHO_P(OP_ECHO), .OP_ADD_P(OP_ADD)) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .rx_tdata_i  (rx_tdata),
      .rx_tvalid_i (rx_tvalid),
      .rx_tready_o (rx_tready_o),
      .tx_tdata_o  (tx_tdata_o),
      .tx_tvalid_o (tx_tvalid_o),
      .tx_tready_i (tx_tready),
      .busy_o      (busy_o),
      .err_op_o    (err_op_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Transmitter ready generator.
   initial begin
      tx_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (tx_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = 1'($urandom_range(1));
            2:       tx_tready = ~tx_tready;
            default: tx_tready = 1'b0;
         endcase
      end
   end

   // Monitor: records every tx transfer and every err_op_o cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1) begin
            if (tx_tvalid_o === 1'b1 && tx_tready === 1'b1) got_q.push_back(tx_tdata_o);
            if (err_op_o === 1'b1) err_cnt++;
         end
      end
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packet-level reference: what the transmitter should see, and how many
   // opcode errors should be flagged, for one complete packet.
   function automatic void model_pkt(input bq_t p);
      int len;
      int n;
      longint unsigned sum;
      longint unsigned word;
      len = int'(p[2]) + 256 * int'(p[3]);
      n   = (len < 4) ? 0 : len - 4;
      sum = 0;
      if (p[0] == OP_ECHO) begin
         for (int i = 0; i < n; i++) exp_q.push_back(p[4 + i]);
      end else if (p[0] == OP_ADD) begin
         for (int w = 0; w < n; w += 4) begin
            word = 0;
            for (int k = 0; k < 4; k++)
               if (w + k < n) word += longint'(p[4 + w + k]) * (longint'(1) << (8 * k));
            sum += word;
         end
         sum = sum % (longint'(1) << 32);
         for (int k = 0; k < 4; k++) exp_q.push_back(8'(sum >> (8 * k)));
      end else begin
         exp_err++;
      end
   endfunction

   function automatic bq_t rand_pkt();
      bq_t p;
      int sel;
      int n;
      logic [7:0] op;
      logic [15:0] len;
      sel = int'($urandom_range(2));
      n   = int'($urandom_range(18));
      if (sel == 0) op = OP_ECHO;
      else if (sel == 1) op = OP_ADD;
      else begin
         op = 8'($urandom);
         while (op == OP_ECHO || op == OP_ADD) op = 8'($urandom);
      end
      if ($urandom_range(7) == 0) begin
         n   = 0;
         len = 16'($urandom_range(3));
      end else begin
         len = 16'(n + 4);
      end
      p.push_back(op);
      p.push_back(8'($urandom));
      p.push_back(len[7:0]);
      p.push_back(len[15:8]);
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   task automatic send_pkt(input bq_t p);
      int   i;
      int   guard;
      logic hs;
      i = 0;
      guard = 0;
      while (i < p.size() && guard < 4000) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            rx_tvalid = 1'b0;
            rx_tdata  = 8'($urandom);
         end else begin
            rx_tvalid = 1'b1;
            rx_tdata  = p[i];
         end
         @(negedge clk);
         hs = rx_tvalid && (rx_tready_o === 1'b1);
         @(posedge clk);
         #1;
         if (hs) i++;
         guard++;
      end
      rx_tvalid = 1'b0;
      if (i < p.size()) chk_val("rx_accept_timeout", i, p.size());
   endtask

   task automatic play(input bq_t p);
      model_pkt(p);
      send_pkt(p);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((busy_o !== 1'b0 || tx_tvalid_o !== 1'b0) && k < 3000);
      if (busy_o !== 1'b0 || tx_tvalid_o !== 1'b0) chk_val("idle_timeout", busy_o, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_stream(input string tag);
      int n;
      wait_idle();
      n = got_q.size() - got_base;
      chk_val({tag, "_txcount"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         chk_val({tag, "_txbyte"}, got_q[got_base + i], exp_q[i]);
      chk_val({tag, "_errcount"}, err_cnt - err_base, exp_err);
      got_base = got_q.size();
      err_base = err_cnt;
      exp_q.delete();
      exp_err = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_val({tag, "_rx_tready"}, rx_tready_o, 0);
      chk_val({tag, "_tx_tvalid"}, tx_tvalid_o, 0);
      chk_val({tag, "_tx_tdata"},  tx_tdata_o, 0);
      chk_val({tag, "_busy"},      busy_o, 0);
      chk_val({tag, "_err_op"},    err_op_o, 0);
   endtask

   task automatic apply_reset();
      rx_tvalid = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("in_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_val("rdy_after_release", rx_tready_o, 1);
      chk_val("busy_after_release", busy_o, 0);
      @(posedge clk);
      #1;
      got_base = got_q.size();
      err_base = err_cnt;
      exp_q.delete();
      exp_err = 0;
   endtask

   initial begin
      int k;
      reset_n   = 1'b0;
      rx_tvalid = 1'b0;
      rx_tdata  = 8'd0;
      tx_mode   = 0;
      gap_pct   = 0;
      got_base  = 0;
      err_base  = 0;
      exp_err   = 0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_val("rdy_first_cycle", rx_tready_o, 1);
      @(posedge clk);
      #1;

      // Two-word add
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      play(pkt);
      cmp_stream("add_basic");
      chk_val("busy_after_add", busy_o, 0);

      // Carry out discarded plus a 2-byte tail operand
      pkt = '{8'hAD, 8'h00, 8'h0A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h00};
      play(pkt);
      cmp_stream("add_overflow");

      // Echo with the transmitter toggling ready
      tx_mode = 2;
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      play(pkt);
      cmp_stream("echo_bp");

      // Unknown opcode followed by an empty add
      tx_mode = 1;
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      play(pkt);
      pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
      play(pkt);
      cmp_stream("unknown_op");

      // Random back-to-back traffic, random rx gaps and tx backpressure
      gap_pct = 30;
      for (int i = 0; i < 60; i++) begin
         pkt = rand_pkt();
         play(pkt);
      end
      cmp_stream("random_gaps");
      gap_pct = 0;
      for (int i = 0; i < 30; i++) begin
         pkt = rand_pkt();
         play(pkt);
      end
      cmp_stream("random_dense");

      // Stall in SEND: outputs frozen while the transmitter refuses
      tx_mode = 3;
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      play(pkt);
      k = 0;
      do begin @(negedge clk); k++; end while (tx_tvalid_o !== 1'b1 && k < 50);
      chk_val("stall_reach_send", tx_tvalid_o, 1);
      hold_data = tx_tdata_o;
      chk_val("stall_first_byte", hold_data, 8'h78);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_val("stall_tx_tvalid", tx_tvalid_o, 1);
         chk_val("stall_tx_tdata", tx_tdata_o, hold_data);
         chk_val("stall_rx_tready", rx_tready_o, 0);
      end
      tx_mode = 0;
      cmp_stream("stall_release");

      // Reset after two of the four sum bytes have gone out
      tx_mode = 3;
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00};
      send_pkt(pkt);
      k = 0;
      do begin @(negedge clk); k++; end while (tx_tvalid_o !== 1'b1 && k < 50);
      chk_val("rst_send_reach", tx_tvalid_o, 1);
      tx_mode = 0;
      k = 0;
      do begin @(negedge clk); #1; k++; end while ((got_q.size() - got_base) < 2 && k < 50);
      tx_mode = 3;
      chk_val("partial_count", got_q.size() - got_base, 2);
      if (got_q.size() - got_base >= 2) begin
         chk_val("partial_byte0", got_q[got_base], 8'h34);
         chk_val("partial_byte1", got_q[got_base + 1], 8'h12);
      end
      apply_reset();
      tx_mode = 0;
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
      play(pkt);
      cmp_stream("after_reset");

      // Maximum length: an unknown opcode keeps draining well past 100 bytes
      pkt = '{8'h55, 8'h00, 8'hFF, 8'hFF};
      for (int i = 0; i < 100; i++) pkt.push_back(8'($urandom));
      send_pkt(pkt);
      @(negedge clk);
      chk_val("maxlen_busy", busy_o, 1);
      chk_val("maxlen_rx_tready", rx_tready_o, 1);
      chk_val("maxlen_err", err_cnt - err_base, 1);
      apply_reset();
      pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
      play(pkt);
      cmp_stream("echo_after_maxlen");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
